// File: rtl/inst_fetch.sv
// Multi-cycle MIPS fetch stage: RESET -> FETCH -> EXEC loop with PC/next-PC selection.
// Optional misaligned-target trap (HALT state, fault output) enabled by FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic [1:0]  Jump,
  input  logic [1:0]  Branch,
  input  logic        zero,
  input  logic [31:0] reg_target,
  output logic        fault
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC} state_t;
`endif

  state_t      state, state_d;
  logic [31:0] next_pc;
  logic [31:0] commit_pc;
  logic [31:0] br_off;
  logic        taken;
  logic        pc_we;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign br_off    = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign taken     = ((Branch == 2'd1) && zero) || ((Branch == 2'd2) && !zero);

  // Jump outranks Branch; Jump==3 and Branch==3 fall through as "none".
  always_comb begin
    next_pc = pc_plus4;
    if (Jump == 2'd1)
      next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
    else if (Jump == 2'd2)
      next_pc = reg_target;
    else if (taken)
      next_pc = pc_plus4 + br_off;
  end

  always_comb begin
    state_d    = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    fault      = 1'b0;
    pc_we      = 1'b0;
    commit_pc  = next_pc & 32'hFFFF_FFFC;
    case (state)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        if (!stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
          // A misaligned target traps and leaves pc at the offending instruction.
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            pc_we   = 1'b1;
          end
`else
          state_d = S_FETCH;
          pc_we   = 1'b1;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_HALT: fault = 1'b1;
`endif
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      pc    <= RESET_PC;
      inst  <= 32'd0;
    end else begin
      state <= state_d;
      if ((state == S_FETCH) && imem_ready) inst <= imem_rdata;
      if (pc_we) pc <= commit_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized run against a transaction-level model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic [1:0]  Jump = 2'd0;
  logic [1:0]  Branch = 2'd0;
  logic        zero = 1'b0;
  logic [31:0] reg_target = 32'd0;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst(inst),
    .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .Jump(Jump), .Branch(Branch), .zero(zero), .reg_target(reg_target),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Architectural next-PC rule from the ISA view: plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [31:0] rt, input logic [1:0] j,
                                           input logic [1:0] b, input logic z);
    logic [31:0] p4;
    int          off;
    p4  = p + 32'd4;
    off = $signed(ins[15:0]);
    if (j == 2'd1) return {p4[31:28], ins[25:0], 2'b00};
    if (j == 2'd2) return rt;
    if ((b == 2'd1 && z) || (b == 2'd2 && !z)) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0; imem_rdata = 32'd0;
    n_vec++; if (pc !== 32'h3000) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000); end
    n_vec++; if (inst !== 32'd0) begin n_err++; $display("FAIL reset_inst: got %h expected 0", inst); end
    n_vec++; if ({imem_req, inst_valid, fault} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got req/valid/fault=%b expected 000", {imem_req, inst_valid, fault}); end
  endtask

  task automatic test_sequential();
    tick();
    n_vec++; if ({imem_req, inst_valid, imem_addr} !== {2'b10, 32'h3000}) begin n_err++; $display("FAIL seq_fetch0: got req=%b valid=%b addr=%h expected 1 0 3000", imem_req, inst_valid, imem_addr); end
    tick();
    n_vec++; if ({imem_req, inst_valid} !== 2'b01) begin n_err++; $display("FAIL seq_exec0: got req=%b valid=%b expected 0 1", imem_req, inst_valid); end
    tick();
    n_vec++; if ({imem_req, inst_valid, imem_addr} !== {2'b10, 32'h3004}) begin n_err++; $display("FAIL seq_fetch1: got req=%b valid=%b addr=%h expected 1 0 3004", imem_req, inst_valid, imem_addr); end
    tick();
    tick();
    n_vec++; if (imem_addr !== 32'h3008) begin n_err++; $display("FAIL seq_fetch2: got %h expected 3008", imem_addr); end
  endtask

  task automatic test_beq();
    imem_rdata = 32'h1000_FFFF;
    tick();
    n_vec++; if (inst !== 32'h1000_FFFF || pc !== 32'h3008) begin n_err++; $display("FAIL beq_inst: got inst=%h pc=%h expected 1000ffff 3008", inst, pc); end
    Branch = 2'd1; zero = 1'b1;
    tick();
    n_vec++; if (imem_addr !== 32'h3008) begin n_err++; $display("FAIL beq_taken: got %h expected 3008", imem_addr); end
    tick();
    zero = 1'b0;
    tick();
    n_vec++; if (imem_addr !== 32'h300C) begin n_err++; $display("FAIL beq_not_taken: got %h expected 300c", imem_addr); end
    Branch = 2'd0; imem_rdata = 32'd0;
  endtask

  task automatic test_jump();
    tick(); tick();
    n_vec++; if (imem_addr !== 32'h3010) begin n_err++; $display("FAIL jump_pre: got %h expected 3010", imem_addr); end
    imem_rdata = 32'h0800_0C40;
    tick();
    Jump = 2'd1;
    tick();
    n_vec++; if (imem_addr !== 32'h0000_3100) begin n_err++; $display("FAIL j_target: got %h expected 00003100", imem_addr); end
    Jump = 2'd0; imem_rdata = 32'd0;
    tick();
    Jump = 2'd2; reg_target = 32'h0000_3400;
    tick();
    n_vec++; if (imem_addr !== 32'h3400) begin n_err++; $display("FAIL jr_target: got %h expected 3400", imem_addr); end
    Jump = 2'd0;
  endtask

  task automatic test_handshake();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if ({imem_req, inst_valid, imem_addr} !== {2'b10, 32'h3400}) begin n_err++; $display("FAIL wait_ready%0d: got req=%b valid=%b addr=%h expected 1 0 3400", i, imem_req, inst_valid, imem_addr); end
    end
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if ({imem_req, inst_valid, pc, inst} !== {2'b01, 32'h3400, 32'h1234_5678}) begin n_err++; $display("FAIL stall%0d: got req=%b valid=%b pc=%h inst=%h expected 0 1 3400 12345678", i, imem_req, inst_valid, pc, inst); end
    end
    stall = 1'b0; imem_rdata = 32'd0;
    tick();
    n_vec++; if (imem_addr !== 32'h3404) begin n_err++; $display("FAIL post_stall: got %h expected 3404", imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D; rst = 1'b1;
    tick();
    n_vec++; if ({imem_req, inst_valid, pc, inst} !== {2'b00, 32'h3000, 32'd0}) begin n_err++; $display("FAIL rst_midfetch: got req=%b valid=%b pc=%h inst=%h expected 0 0 3000 0", imem_req, inst_valid, pc, inst); end
    rst = 1'b0; imem_rdata = 32'd0;
    tick();
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h3000}) begin n_err++; $display("FAIL rst_refetch: got req=%b addr=%h expected 1 3000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    tick();
    Jump = 2'd2; reg_target = 32'hFFFF_FFFC;
    tick();
    Jump = 2'd0;
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin n_err++; $display("FAIL wrap_top: got addr=%h pc4=%h expected fffffffc 0", imem_addr, pc_plus4); end
    tick(); tick();
    n_vec++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL wrap_zero: got %h expected 0", imem_addr); end
  endtask

  task automatic test_align();
    tick();
    Jump = 2'd2; reg_target = 32'h0000_3402;
    tick();
    Jump = 2'd0;
`ifdef FETCH_ALIGN_CHECK_EN
    n_vec++; if ({fault, imem_req, inst_valid, pc} !== {3'b100, 32'd0}) begin n_err++; $display("FAIL align_trap: got fault=%b req=%b valid=%b pc=%h expected 1 0 0 0", fault, imem_req, inst_valid, pc); end
    tick(); tick();
    n_vec++; if ({fault, imem_req} !== 2'b10) begin n_err++; $display("FAIL align_hold: got fault=%b req=%b expected 1 0", fault, imem_req); end
`else
    n_vec++; if ({fault, imem_req, imem_addr} !== {2'b01, 32'h3400}) begin n_err++; $display("FAIL align_force: got fault=%b req=%b addr=%h expected 0 1 3400", fault, imem_req, imem_addr); end
`endif
  endtask

  task automatic test_random();
    int          mst;  // 0 idle after reset, 1 awaiting memory, 2 executing, 3 trapped
    logic [31:0] mpc, minst, np;
    mst = 0; mpc = 32'h3000; minst = 32'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_vec++;
      if ({imem_req, inst_valid, fault} !== {mst == 1, mst == 2, mst == 3}) begin
        n_err++; $display("FAIL rand_ctrl cyc%0d: got req/valid/fault=%b%b%b expected %b%b%b", cyc, imem_req, inst_valid, fault, mst == 1, mst == 2, mst == 3);
      end
      n_vec++;
      if ({pc, imem_addr, inst, pc_plus4} !== {mpc, mpc, minst, mpc + 32'd4}) begin
        n_err++; $display("FAIL rand_data cyc%0d: got pc=%h addr=%h inst=%h pc4=%h expected pc=%h inst=%h", cyc, pc, imem_addr, inst, pc_plus4, mpc, minst);
      end
      rst        = ($urandom_range(0, 63) == 0) || (mst == 3 && $urandom_range(0, 3) == 0);
      imem_ready = $urandom_range(0, 1) == 1;
      imem_rdata = $urandom;
      stall      = $urandom_range(0, 2) == 0;
      Jump       = 2'($urandom_range(0, 3));
      Branch     = 2'($urandom_range(0, 3));
      zero       = $urandom_range(0, 1) == 1;
      reg_target = {$urandom, 2'b00} >> 0;
      reg_target[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      @(posedge clk);
      if (rst) begin
        mst = 0; mpc = 32'h3000; minst = 32'd0;
      end else if (mst == 0) begin
        mst = 1;
      end else if (mst == 1 && imem_ready) begin
        minst = imem_rdata; mst = 2;
      end else if (mst == 2 && !stall) begin
        np = ref_next(mpc, minst, reg_target, Jump, Branch, zero);
`ifdef FETCH_ALIGN_CHECK_EN
        if (np % 4 != 0) mst = 3;
        else begin mpc = np; mst = 1; end
`else
        mpc = np - (np % 4); mst = 1;
`endif
      end
      @(negedge clk);
    end
    rst = 1'b0; stall = 1'b0; Jump = 2'd0; Branch = 2'd0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_beq();
    test_jump();
    test_handshake();
    test_reset_midfetch();
    test_wrap();
    test_align();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the multi-cycle MIPS CPU. It holds the PC, fetches one instruction at a time from instruction memory over a req/ready handshake, and presents it to the central control decoder. It consumes the decoder's Jump/Branch outcome, together with the ALU zero flag and the register operand, to compute and commit the next PC.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request; held high until accepted.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  memory response valid; imem_rdata is captured when imem_req && imem_ready.
- imem_rdata  in  32  instruction word.
- inst  out  32  held instruction; feeds the control decoder.
- inst_valid  out  1  inst is valid and executing.
- pc  out  32  address of inst.
- pc_plus4  out  32  pc + 4; write data for jal/jalr.
- stall  in  1  downstream not finished; holds the current instruction.
- Jump  in  2  0 none, 1 imm26 target, 2 register target.
- Branch  in  2  0 none, 1 beq, 2 bne.
- zero  in  1  ALU result == 0.
- reg_target  in  32  register file RD1; jr/jalr target.
- fault  out  1  misaligned-target trap; only meaningful when FETCH_ALIGN_CHECK_EN is defined.

## Operation
- States: RESET, FETCH, EXEC, HALT (HALT exists only when FETCH_ALIGN_CHECK_EN is defined).
- RESET: imem_req=0 and inst_valid=0. Goes to FETCH on the next edge.
- FETCH: imem_req=1 and imem_addr=pc.
  - On an edge with imem_ready=1: inst <= imem_rdata, then go to EXEC.
  - Otherwise stay in FETCH with address and request stable.
- EXEC: inst_valid=1 and imem_req=0.
  - On an edge with stall=0: pc <= next_pc, then go to FETCH.
  - On an edge with stall=1: hold pc, inst and state.
- next_pc is combinational, evaluated in EXEC, with this priority:
  - Jump==1: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - Jump==2: reg_target.
  - Jump==3: treated as 0.
  - Taken branch, i.e. (Branch==1 && zero) or (Branch==2 && !zero): pc_plus4 + {sext(inst[15:0]), 2'b00}, 32-bit modulo.
  - Branch==3: not taken.
  - Otherwise: pc_plus4.
- Arithmetic: all adds are 32-bit and wrap; 32'hFFFF_FFFC + 4 = 0.
- imem_ready asserted outside FETCH is ignored; rdata is not captured.
- Reset values: pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, fault=0, state=RESET.

## Timing
- Minimum cost is 2 cycles per instruction: one FETCH cycle with imem_ready=1, plus one EXEC cycle with stall=0.
- Each extra FETCH cycle without ready adds 1 cycle; each EXEC cycle with stall=1 adds 1 cycle.
- inst and inst_valid update on the edge after the handshake. Decoder outputs are valid in that same EXEC cycle.
- pc changes only on the EXEC→FETCH edge. imem_addr for the new fetch is valid in the first FETCH cycle.
- At most one request is outstanding; there is no prefetch.
- rst overrides everything, including an in-flight handshake. A response that arrives in the reset cycle is discarded. The first fetch after reset is issued in cycle 2 (RESET, then FETCH).

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - An EXEC commit with next_pc[1:0] != 0 goes to HALT instead of FETCH.
  - pc keeps the faulting instruction's address.
  - fault=1, inst_valid=0 and imem_req=0 until rst.
- FETCH_ALIGN_CHECK_EN undefined:
  - next_pc[1:0] is forced to 2'b00 on commit.
  - fault is tied to 0 and no HALT state exists.

## Test plan
- Sequential fetch: reset with RESET_PC=0x3000, imem_ready=1 always, Jump=Branch=0. imem_addr is 0x3000 in cycle 2 and 0x3004 two cycles later; inst_valid toggles 0/1 each cycle.
- beq taken: inst=0x1000_FFFF at pc 0x3008, Branch=1, zero=1. Next fetch address is 0x3008. With zero=0 the next fetch address is 0x300C.
- Jumps:
  - j: pc=0x3010, inst=0x0800_0C40, Jump=1 → next pc 0x0000_3100.
  - jr: Jump=2, reg_target=0x0000_3400 → next pc 0x3400.
- Handshake/stall: hold imem_ready=0 for 3 cycles; imem_req and imem_addr stay stable. Hold stall=1 for 2 EXEC cycles; inst and pc are unchanged and no request is issued.
- Reset mid-fetch: assert rst in FETCH while imem_ready=1. inst stays 0, pc=RESET_PC, and imem_req=0 in the following cycle.
- Alignment: jr to 0x3402.
  - With FETCH_ALIGN_CHECK_EN: fault=1 and no further imem_req.
  - Without it: next fetch address is 0x3400.
